// File: rtl/spi_sram_pkg.sv
// Shared opcodes, default geometry and FSM encoding for the SPI/QPI serial-SRAM responder.
package spi_sram_pkg;

  localparam int DEF_MEM_ADDR_WIDTH = 10;
  localparam int DEF_ADDR_BYTES     = 3;
  localparam int DEF_DUMMY_BYTES    = 1;

  localparam logic [7:0] OPC_READ  = 8'h03;
  localparam logic [7:0] OPC_WRITE = 8'h02;
  localparam logic [7:0] OPC_EQIO  = 8'h38;
  localparam logic [7:0] OPC_RSTIO = 8'hFF;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_ADDR   = 3'd2;
  localparam state_t ST_DUMMY  = 3'd3;
  localparam state_t ST_RDATA  = 3'd4;
  localparam state_t ST_WDATA  = 3'd5;
  localparam state_t ST_IGNORE = 3'd6;

  // SPI answers on SO (sio[1]) only; QPI drives all four pins.
  function automatic logic [3:0] drive_mask(input logic qpi);
    return qpi ? 4'b1111 : 4'b0010;
  endfunction

endpackage

// File: rtl/spi_sram_if.sv
// Pin-level bundle between an SRAM controller (master) and the serial-SRAM responder (slave).
interface spi_sram_if;
  logic       cs_in;
  logic       sck_in;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic [3:0] sio_oe;
  logic       qpi_mode;
  logic       busy;
  logic       cmd_err;

  modport master (
    output cs_in, sck_in, sio_in,
    input  sio_out, sio_oe, qpi_mode, busy, cmd_err
  );

  modport slave (
    input  cs_in, sck_in, sio_in,
    output sio_out, sio_oe, qpi_mode, busy, cmd_err
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for cs/sck/sio with single-cycle edge pulses on the synchronized values.
module spi_pin_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_in,
  input  logic       sck_in,
  input  logic [3:0] sio_in,
  output logic       cs_s,
  output logic [3:0] sio_s,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       cs_fall,
  output logic       cs_rise
);

  // Bit 0 is the metastability flop, bit 1 the synchronized value, bit 2 its previous value.
  logic [2:0] cs_q, cs_d;
  logic [2:0] sck_q, sck_d;
  logic [3:0] sio_meta_q, sio_meta_d;
  logic [3:0] sio_sync_q, sio_sync_d;

  always_comb begin
    cs_d       = {cs_q[1:0], cs_in};
    sck_d      = {sck_q[1:0], sck_in};
    sio_meta_d = sio_in;
    sio_sync_d = sio_meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q       <= 3'b111;
      sck_q      <= 3'b000;
      sio_meta_q <= 4'h0;
      sio_sync_q <= 4'h0;
    end else begin
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      sio_meta_q <= sio_meta_d;
      sio_sync_q <= sio_sync_d;
    end
  end

  assign cs_s     = cs_q[1];
  assign sio_s    = sio_sync_q;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];

endmodule

// File: rtl/spi_sram_target.sv
// SPI/QPI serial-SRAM responder: decodes READ/WRITE/EQIO/RSTIO from oversampled pins into an internal byte RAM.
module spi_sram_target
  import spi_sram_pkg::*;
#(
  parameter int         MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int         ADDR_BYTES     = DEF_ADDR_BYTES,
  parameter int         DUMMY_BYTES    = DEF_DUMMY_BYTES,
  parameter logic [7:0] CMD_READ       = OPC_READ,
  parameter logic [7:0] CMD_WRITE      = OPC_WRITE,
  parameter logic [7:0] CMD_EQIO       = OPC_EQIO,
  parameter logic [7:0] CMD_RSTIO      = OPC_RSTIO
) (
  input logic        clk,
  input logic        rst,
  spi_sram_if.slave  bus
);

  localparam int                  SHIFT_W   = ADDR_BYTES * 8;
  localparam logic [7:0]          ADDR_BITS = 8'(ADDR_BYTES * 8);
  localparam logic [7:0]          DUMMY_CNT = 8'(DUMMY_BYTES * 2);
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic       cs_s, sck_rise, sck_fall, cs_fall, cs_rise;
  logic [3:0] sio_s;

  spi_pin_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .cs_in    (bus.cs_in),
    .sck_in   (bus.sck_in),
    .sio_in   (bus.sio_in),
    .cs_s     (cs_s),
    .sio_s    (sio_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise)
  );

  state_t                    state_q, state_d;
  logic [7:0]                bit_cnt_q, bit_cnt_d;
  logic [SHIFT_W-1:0]        shift_q, shift_d, shift_in;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      is_read_q, is_read_d;
  logic                      qpi_q, qpi_d;
  logic [7:0]                dout_q, dout_d;
  logic [3:0]                out_cnt_q, out_cnt_d, out_next;
  logic [3:0]                sio_out_q, sio_out_d;
  logic [3:0]                sio_oe_q, sio_oe_d;
  logic                      cmd_err_q, cmd_err_d;
  logic [7:0]                step, cnt_next, op, byte_sel;
  logic                      ram_we;
  logic [7:0]                ram_rdata_q;
  logic [7:0]                mem_q [2**MEM_ADDR_WIDTH];
  logic                      unused_shift_msb;

  assign unused_shift_msb = shift_q[SHIFT_W-1];

  // One sck rise shifts in a bit (SPI) or a nibble (QPI); one sck fall shifts out the same width.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    is_read_d = is_read_q;
    qpi_d     = qpi_q;
    dout_d    = dout_q;
    out_cnt_d = out_cnt_q;
    sio_out_d = sio_out_q;
    sio_oe_d  = sio_oe_q;
    cmd_err_d = 1'b0;
    ram_we    = 1'b0;
    step      = qpi_q ? 8'd4 : 8'd1;
    cnt_next  = bit_cnt_q + step;
    out_next  = out_cnt_q + step[3:0];
    shift_in  = qpi_q ? {shift_q[SHIFT_W-5:0], sio_s} : {shift_q[SHIFT_W-2:0], sio_s[0]};
    op        = shift_in[7:0];
    byte_sel  = (out_cnt_q == 4'd0) ? ram_rdata_q : dout_q;

    if (cs_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 8'd0;
      out_cnt_d = 4'd0;
      sio_oe_d  = 4'h0;
      sio_out_d = 4'h0;
    end else if (cs_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = 8'd0;
      out_cnt_d = 4'd0;
      shift_d   = '0;
    end else if (sck_rise) begin
      case (state_q)
        ST_CMD: begin
          shift_d   = shift_in;
          bit_cnt_d = cnt_next;
          if (cnt_next == 8'd8) begin
            bit_cnt_d = 8'd0;
            state_d   = ST_IGNORE;
            if (op == CMD_READ || op == CMD_WRITE) begin
              is_read_d = (op == CMD_READ);
              state_d   = ST_ADDR;
            end else if (op == CMD_EQIO) begin
              qpi_d = 1'b1;
            end else if (op == CMD_RSTIO) begin
              qpi_d = 1'b0;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
        end
        ST_ADDR: begin
          shift_d   = shift_in;
          bit_cnt_d = cnt_next;
          if (cnt_next == ADDR_BITS) begin
            bit_cnt_d = 8'd0;
            out_cnt_d = 4'd0;
            addr_d    = shift_in[MEM_ADDR_WIDTH-1:0];
            if (!is_read_q)                       state_d = ST_WDATA;
            else if (qpi_q && (DUMMY_BYTES > 0))  state_d = ST_DUMMY;
            else                                  state_d = ST_RDATA;
          end
        end
        ST_DUMMY: begin
          bit_cnt_d = bit_cnt_q + 8'd1;
          if (bit_cnt_d == DUMMY_CNT) begin
            bit_cnt_d = 8'd0;
            state_d   = ST_RDATA;
          end
        end
        ST_WDATA: begin
          shift_d   = shift_in;
          bit_cnt_d = cnt_next;
          if (cnt_next == 8'd8) begin
            bit_cnt_d = 8'd0;
            ram_we    = 1'b1;
            addr_d    = addr_q + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end else if (sck_fall && state_q == ST_RDATA) begin
      // The first fall of each byte takes the freshly fetched RAM word; later falls drain the shifter.
      sio_oe_d  = drive_mask(qpi_q);
      sio_out_d = qpi_q ? byte_sel[7:4] : {2'b00, byte_sel[7], 1'b0};
      dout_d    = qpi_q ? {byte_sel[3:0], 4'h0} : {byte_sel[6:0], 1'b0};
      out_cnt_d = out_next;
      if (out_next == 4'd8) begin
        out_cnt_d = 4'd0;
        addr_d    = addr_q + ADDR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 8'd0;
      shift_q   <= '0;
      addr_q    <= '0;
      is_read_q <= 1'b0;
      qpi_q     <= 1'b0;
      dout_q    <= 8'h00;
      out_cnt_q <= 4'd0;
      sio_out_q <= 4'h0;
      sio_oe_q  <= 4'h0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      is_read_q <= is_read_d;
      qpi_q     <= qpi_d;
      dout_q    <= dout_d;
      out_cnt_q <= out_cnt_d;
      sio_out_q <= sio_out_d;
      sio_oe_q  <= sio_oe_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Single-port RAM: the read port continuously tracks addr_q so the next byte is ready before its first fall.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[addr_q] <= shift_in[7:0];
    else        ram_rdata_q   <= mem_q[addr_q];
  end

  assign bus.sio_out  = sio_out_q;
  assign bus.sio_oe   = cs_rise ? 4'h0 : sio_oe_q;
  assign bus.qpi_mode = qpi_q;
  assign bus.busy     = ~cs_s;
  assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_sram_target.sv
// Self-checking bench for spi_sram_target: drives SPI/QPI transactions and scores read data against a byte model.
module tb_spi_sram_target;

  localparam int MW   = 10;
  localparam int MSZ  = 1 << MW;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst;

  spi_sram_if bus ();

  spi_sram_target #(.MEM_ADDR_WIDTH(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         err_pulses = 0;
  logic [7:0] model [MSZ];
  logic [7:0] exp_q [$];
  logic [7:0] wbuf [8];
  bit         quad = 1'b0;

  always @(posedge clk) if (bus.cmd_err === 1'b1) err_pulses++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sck period: present data while low, sample the DUT just before the rise.
  task automatic applyStimulus(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] oe);
    bus.sio_in = din;
    wait_clk(HALF);
    dout = bus.sio_out;
    oe   = bus.sio_oe;
    bus.sck_in = 1'b1;
    wait_clk(HALF);
    bus.sck_in = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx,
                           output logic [3:0] oe_or, output logic [3:0] oe_and);
    logic [3:0] d, oe;
    rx = 8'h00; oe_or = 4'h0; oe_and = 4'hF;
    if (quad) begin
      for (int i = 0; i < 2; i++) begin
        applyStimulus((i == 0) ? tx[7:4] : tx[3:0], d, oe);
        rx = {rx[3:0], d};
        oe_or |= oe; oe_and &= oe;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        applyStimulus({3'b000, tx[7-i]}, d, oe);
        rx = {rx[6:0], d[1]};
        oe_or |= oe; oe_and &= oe;
      end
    end
  endtask

  task automatic begin_cs();
    bus.cs_in = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic end_cs();
    wait_clk(HALF);
    bus.cs_in = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic send_header(input logic [7:0] op, input logic [23:0] addr, output logic [3:0] oe_acc);
    logic [7:0] rx;
    logic [3:0] o_or, o_and;
    xfer_byte(op, rx, o_or, o_and);
    oe_acc = o_or;
    for (int i = 0; i < 3; i++) begin
      xfer_byte(addr[23-8*i -: 8], rx, o_or, o_and);
      oe_acc |= o_or;
    end
  endtask

  task automatic do_write(input logic [23:0] addr, input int n);
    logic [7:0] rx;
    logic [3:0] o_or, o_and, hdr_oe;
    begin_cs();
    send_header(8'h02, addr, hdr_oe);
    for (int i = 0; i < n; i++) begin
      xfer_byte(wbuf[i], rx, o_or, o_and);
      model[(int'(addr) + i) % MSZ] = wbuf[i];
    end
    end_cs();
  endtask

  task automatic do_read(input logic [23:0] addr, input int n, input string tag);
    logic [7:0] rx, exp;
    logic [3:0] o_or, o_and, hdr_oe;
    logic [3:0] oe_exp;
    oe_exp = quad ? 4'hF : 4'h2;
    begin_cs();
    send_header(8'h03, addr, hdr_oe);
    if (quad) begin
      xfer_byte(8'h00, rx, o_or, o_and);
      hdr_oe |= o_or;
    end
    checkOutput({tag, "_hdr_oe"}, hdr_oe, 4'h0);
    for (int i = 0; i < n; i++) exp_q.push_back(model[(int'(addr) + i) % MSZ]);
    for (int i = 0; i < n; i++) begin
      xfer_byte(8'h00, rx, o_or, o_and);
      exp = exp_q.pop_front();
      checkOutput(tag, rx, exp);
      checkOutput({tag, "_oe"}, {o_or, o_and}, {oe_exp, oe_exp});
    end
    end_cs();
    checkOutput({tag, "_oe_idle"}, bus.sio_oe, 4'h0);
  endtask

  initial begin
    logic [7:0] rx;
    logic [3:0] d, oe, o_or, o_and, acc;

    rst = 1'b1;
    bus.cs_in = 1'b1;
    bus.sck_in = 1'b0;
    bus.sio_in = 4'h0;
    wait_clk(3);
    checkOutput("rst_sio_oe", bus.sio_oe, 4'h0);
    checkOutput("rst_sio_out", bus.sio_out, 4'h0);
    checkOutput("rst_qpi", bus.qpi_mode, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_cmd_err", bus.cmd_err, 1'b0);
    rst = 1'b0;
    wait_clk(3);

    bus.cs_in = 1'b0;
    wait_clk(4);
    checkOutput("busy_low_cs", bus.busy, 1'b1);
    bus.cs_in = 1'b1;
    wait_clk(6);
    checkOutput("busy_high_cs", bus.busy, 1'b0);

    wbuf[0] = 8'h12; wbuf[1] = 8'h34; wbuf[2] = 8'h56; wbuf[3] = 8'h78;
    do_write(24'h001234, 4);
    do_read(24'h001234, 4, "spi_rd");

    begin_cs();
    xfer_byte(8'h38, rx, o_or, o_and);
    end_cs();
    quad = 1'b1;
    checkOutput("eqio_qpi", bus.qpi_mode, 1'b1);

    wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
    do_write(24'h000010, 2);
    do_read(24'h000010, 2, "qpi_rd");

    wbuf[0] = 8'h5A; wbuf[1] = 8'hC7; wbuf[2] = 8'h3E;
    do_write(24'hABC000 | 24'(MSZ - 1), 3);
    do_read(24'(MSZ - 1), 3, "wrap_rd");

    begin_cs();
    xfer_byte(8'hFF, rx, o_or, o_and);
    end_cs();
    quad = 1'b0;
    checkOutput("rstio_qpi", bus.qpi_mode, 1'b0);
    checkOutput("mode_cmd_err", err_pulses, 0);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(24'h000200, 2);
    begin_cs();
    send_header(8'h02, 24'h000200, acc);
    xfer_byte(8'hC3, rx, o_or, o_and);
    for (int i = 0; i < 4; i++) applyStimulus({3'b000, i[0] ? 1'b0 : 1'b1}, d, oe);
    end_cs();
    model[12'h200] = 8'hC3;
    do_read(24'h000200, 2, "part_rd");

    begin_cs();
    xfer_byte(8'h9F, rx, o_or, o_and);
    acc = o_or;
    for (int i = 0; i < 4; i++) begin
      xfer_byte(8'hEE, rx, o_or, o_and);
      acc |= o_or;
    end
    end_cs();
    checkOutput("bad_cmd_err", err_pulses, 1);
    checkOutput("bad_oe", acc, 4'h0);
    checkOutput("bad_qpi", bus.qpi_mode, 1'b0);
    do_read(24'h000200, 2, "bad_rd");

    begin_cs();
    xfer_byte(8'h38, rx, o_or, o_and);
    end_cs();
    quad = 1'b1;
    begin_cs();
    send_header(8'h03, 24'h000010, acc);
    xfer_byte(8'h00, rx, o_or, o_and);
    applyStimulus(4'h0, d, oe);
    checkOutput("mid_nibble", d, 4'hA);
    checkOutput("mid_oe", oe, 4'hF);
    wait_clk(2);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_oe", bus.sio_oe, 4'h0);
    checkOutput("mid_rst_qpi", bus.qpi_mode, 1'b0);
    bus.cs_in = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
    quad = 1'b0;
    do_read(24'h001234, 4, "post_rst_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
